// File: rtl/game_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : game_compositor
//  Purpose  : Sprite-layer compositor with a small run/dead game controller.
//             Each pixel, the layer flags are folded into a two-stage colour
//             pipeline (white > grey > screen background > black). Overlaps
//             between the player layer (0) and the masked enemy layers are
//             collected over a frame. A frame that ends with any overlap
//             kills the player at the next frame_start.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             pix_en              - pixel strobe (pipeline enable)
//             x, y                - scan position
//             frame_start         - first-pixel-of-frame pulse
//             layer_grey/white    - per-layer dark/light pixel flags
//             jump/restart/night  - game-control levels
//             vgaRed/Green/Blue   - registered colour (3/3/2 bits)
//             state               - {run, dead}
//             collided, hit_layer - death indication and culprit layers
//             frames_alive        - frames survived in current/last run
//  Revision : 1.0 - initial release
// ============================================================================
module game_compositor #(
    parameter int                    NUM_LAYERS   = 4,
    parameter logic [NUM_LAYERS-1:0] COLL_MASK    = {NUM_LAYERS{1'b1}},
    parameter int                    GRACE_FRAMES = 8,
    parameter int                    SCREEN_W     = 640,
    parameter int                    SCREEN_H     = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_en,
    input  logic [9:0]            x,
    input  logic [8:0]            y,
    input  logic                  frame_start,
    input  logic [NUM_LAYERS-1:0] layer_grey,
    input  logic [NUM_LAYERS-1:0] layer_white,
    input  logic                  jump,
    input  logic                  restart,
    input  logic                  night,
    output logic [2:0]            vgaRed,
    output logic [2:0]            vgaGreen,
    output logic [1:0]            vgaBlue,
    output logic [1:0]            state,
    output logic                  collided,
    output logic [NUM_LAYERS-1:0] hit_layer,
    output logic [15:0]           frames_alive
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b10;
    localparam logic [1:0] S_DEAD = 2'b01;

    localparam int         GW           = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES + 1) : 1;
    localparam logic [GW-1:0] C_GRACE_INIT = GW'(GRACE_FRAMES);

    localparam logic [9:0] C_SCREEN_W = 10'(SCREEN_W);
    localparam logic [8:0] C_SCREEN_H = 9'(SCREEN_H);

    localparam logic [7:0] C_LIGHT = 8'hFF;
    localparam logic [7:0] C_DARK  = 8'h00;
    localparam logic [7:0] C_BLACK = 8'h00;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]            state_q, state_d;
    logic                  collided_q;
    logic [NUM_LAYERS-1:0] hit_q, hit_d;
    logic [NUM_LAYERS-1:0] acc_q, acc_d;
    logic [GW-1:0]         grace_q, grace_d;
    logic [15:0]           frames_q, frames_d;
    logic                  jump_prev_q;
    logic                  night_q;
    logic                  any_white_q;
    logic                  any_grey_q;
    logic                  in_screen_q;
    logic [7:0]            rgb_q, rgb_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  jump_rise;
    logic                  state_change;
    logic                  enter_run;
    logic                  run_to_dead;
    logic                  in_screen;
    logic [NUM_LAYERS-1:0] hit_vec;
    logic [7:0]            light_col;
    logic [7:0]            dark_col;

    // jump_prev_q resets to 1 so a jump held through reset is not an edge.
    assign jump_rise    = jump & ~jump_prev_q;

    assign in_screen    = (x != 10'd0) && (x <= C_SCREEN_W) &&
                          (y != 9'd0)  && (y <= C_SCREEN_H);

    // Player overlap: every masked enemy layer that is dark on the same
    // pixel as the player. Bit 0 (the player itself) never reports.
    always_comb begin
        hit_vec = '0;
        if (pix_en && (state_q == S_RUN) && (grace_q == '0)) begin
            hit_vec = {layer_grey[NUM_LAYERS-1:1] &
                       COLL_MASK[NUM_LAYERS-1:1] &
                       {(NUM_LAYERS-1){layer_grey[0]}}, 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Game state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!restart && jump_rise)                 state_d = S_RUN;
            S_RUN: begin
                if (restart)                                   state_d = S_IDLE;
                else if (frame_start && (acc_q != '0))         state_d = S_DEAD;
            end
            S_DEAD: if (restart)                               state_d = S_IDLE;
            default:                                           state_d = S_IDLE;
        endcase
    end

    assign state_change = (state_d != state_q);
    assign enter_run    = (state_q != S_RUN) && (state_d == S_RUN);
    assign run_to_dead  = (state_q == S_RUN) && (state_d == S_DEAD);

    // Accumulator: frame_start starts a fresh frame but the pixel on that
    // same clock already belongs to the new frame, hence the OR after clear.
    always_comb begin
        if (state_change) begin
            acc_d = '0;
        end else begin
            acc_d = (frame_start ? '0 : acc_q) | hit_vec;
        end
    end

    always_comb begin
        hit_d = hit_q;
        if (run_to_dead) begin
            hit_d = acc_q;
        end else if (state_d == S_IDLE) begin
            hit_d = '0;
        end
    end

    always_comb begin
        grace_d = grace_q;
        if (enter_run) begin
            grace_d = C_GRACE_INIT;
        end else if ((state_q == S_RUN) && frame_start && (grace_q != '0)) begin
            grace_d = grace_q - 1'b1;
        end
    end

    always_comb begin
        frames_d = frames_q;
        if ((state_q == S_IDLE) && (state_d == S_RUN)) begin
            frames_d = '0;
        end else if ((state_q == S_RUN) && frame_start && (frames_q != 16'hFFFF)) begin
            frames_d = frames_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            collided_q  <= 1'b0;
            hit_q       <= '0;
            acc_q       <= '0;
            grace_q     <= '0;
            frames_q    <= '0;
            jump_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            collided_q  <= (state_d == S_DEAD);
            hit_q       <= hit_d;
            acc_q       <= acc_d;
            grace_q     <= grace_d;
            frames_q    <= frames_d;
            jump_prev_q <= jump;
        end
    end

    // ------------------------------------------------------------------
    // Colour pipeline
    // ------------------------------------------------------------------
    // Night swaps light/dark; the off-screen black is outside the swap.
    assign light_col = night_q ? C_DARK  : C_LIGHT;
    assign dark_col  = night_q ? C_LIGHT : C_DARK;

    always_comb begin
        if (any_white_q) begin
            rgb_d = light_col;
        end else if (any_grey_q) begin
            rgb_d = dark_col;
        end else if (in_screen_q) begin
            rgb_d = light_col;
        end else begin
            rgb_d = C_BLACK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            night_q     <= 1'b0;
            any_white_q <= 1'b0;
            any_grey_q  <= 1'b0;
            in_screen_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            // Palette is latched only at frame boundaries.
            if (frame_start) begin
                night_q <= night;
            end
            if (pix_en) begin
                any_white_q <= |layer_white;
                any_grey_q  <= |layer_grey;
                in_screen_q <= in_screen;
                rgb_q       <= rgb_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign vgaRed       = rgb_q[7:5];
    assign vgaGreen     = rgb_q[4:2];
    assign vgaBlue      = rgb_q[1:0];
    assign state        = state_q;
    assign collided     = collided_q;
    assign hit_layer    = hit_q;
    assign frames_alive = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_game_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_compositor
//  Purpose  : Self-checking bench for game_compositor. Two instances share
//             all inputs: u_a uses the default collision mask, u_b uses
//             mask 4'b1011. A behavioural game model predicts every output
//             on every clock; a colour table and directed game sequences
//             add hand-derived expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_compositor;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pix_en;
    logic [9:0]    x;
    logic [8:0]    y;
    logic          frame_start;
    logic [NL-1:0] layer_grey;
    logic [NL-1:0] layer_white;
    logic          jump;
    logic          restart;
    logic          night;

    logic [2:0]    a_red, b_red, a_green, b_green;
    logic [1:0]    a_blue, b_blue, a_state, b_state;
    logic          a_coll, b_coll;
    logic [NL-1:0] a_hit, b_hit;
    logic [15:0]   a_frames, b_frames;

    always #5 clk = ~clk;

    game_compositor u_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y),
        .frame_start(frame_start), .layer_grey(layer_grey), .layer_white(layer_white),
        .jump(jump), .restart(restart), .night(night),
        .vgaRed(a_red), .vgaGreen(a_green), .vgaBlue(a_blue), .state(a_state),
        .collided(a_coll), .hit_layer(a_hit), .frames_alive(a_frames)
    );

    game_compositor #(.COLL_MASK(4'b1011)) u_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y),
        .frame_start(frame_start), .layer_grey(layer_grey), .layer_white(layer_white),
        .jump(jump), .restart(restart), .night(night),
        .vgaRed(b_red), .vgaGreen(b_green), .vgaBlue(b_blue), .state(b_state),
        .collided(b_coll), .hit_layer(b_hit), .frames_alive(b_frames)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Modes: 0 idle, 1 running, 2 dead.
    // Colour categories: 0 black, 1 light, 2 dark.
    // ------------------------------------------------------------------
    int          m_mode[2];
    logic [3:0]  m_acc[2];
    logic [3:0]  m_hit[2];
    int          m_grace[2];
    int          m_frames[2];
    logic [3:0]  m_mask[2];
    bit          m_prevjump;
    bit          m_night;
    int          m_cat;
    logic [7:0]  m_rgb;

    function automatic logic [1:0] enc(input int mode);
        if (mode == 1) return 2'b10;
        if (mode == 2) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [7:0] palette(input int cat, input bit nt);
        if (cat == 0) return 8'h00;
        if (cat == 1) return nt ? 8'h00 : 8'hFF;
        return nt ? 8'hFF : 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]   = 0;
            m_acc[i]    = 4'b0;
            m_hit[i]    = 4'b0;
            m_grace[i]  = 0;
            m_frames[i] = 0;
        end
        m_mask[0]  = 4'b1111;
        m_mask[1]  = 4'b1011;
        m_prevjump = 1'b1;
        m_night    = 1'b0;
        m_cat      = 0;
        m_rgb      = 8'h00;
    endtask

    task automatic model_step();
        bit         rise;
        int         oldm, newm;
        logic [3:0] h;
        bool_blk: begin end
        rise = jump && !m_prevjump;
        for (int i = 0; i < 2; i++) begin
            oldm = m_mode[i];
            if (restart)                                        newm = 0;
            else if (oldm == 0 && rise)                         newm = 1;
            else if (oldm == 1 && frame_start && m_acc[i] != 0) newm = 2;
            else                                                newm = oldm;

            h = 4'b0;
            if (pix_en && oldm == 1 && m_grace[i] == 0) begin
                for (int k = 1; k < NL; k++)
                    h[k] = layer_grey[k] && layer_grey[0] && m_mask[i][k];
            end

            if (oldm == 1 && newm == 2) m_hit[i] = m_acc[i];
            else if (newm == 0)         m_hit[i] = 4'b0;

            if (newm != oldm) m_acc[i] = 4'b0;
            else              m_acc[i] = (frame_start ? 4'b0 : m_acc[i]) | h;

            if (oldm == 0 && newm == 1)                              m_frames[i] = 0;
            else if (oldm == 1 && frame_start && m_frames[i] < 65535) m_frames[i]++;

            if (oldm != 1 && newm == 1)                          m_grace[i] = 8;
            else if (oldm == 1 && frame_start && m_grace[i] > 0) m_grace[i]--;

            m_mode[i] = newm;
        end
        if (pix_en) begin
            m_rgb = palette(m_cat, m_night);
            if (|layer_white)      m_cat = 1;
            else if (|layer_grey)  m_cat = 2;
            else if (x >= 1 && x <= 640 && y >= 1 && y <= 480) m_cat = 1;
            else                   m_cat = 0;
        end
        if (frame_start) m_night = night;
        m_prevjump = jump;
    endtask

    task automatic check_all();
        chk("a_state",  {30'b0, a_state}, {30'b0, enc(m_mode[0])});
        chk("a_coll",   {31'b0, a_coll},  {31'b0, m_mode[0] == 2});
        chk("a_hit",    {28'b0, a_hit},   {28'b0, m_hit[0]});
        chk("a_frames", {16'b0, a_frames}, m_frames[0]);
        chk("a_rgb",    {24'b0, a_red, a_green, a_blue}, {24'b0, m_rgb});
        chk("b_state",  {30'b0, b_state}, {30'b0, enc(m_mode[1])});
        chk("b_coll",   {31'b0, b_coll},  {31'b0, m_mode[1] == 2});
        chk("b_hit",    {28'b0, b_hit},   {28'b0, m_hit[1]});
        chk("b_frames", {16'b0, b_frames}, m_frames[1]);
        chk("b_rgb",    {24'b0, b_red, b_green, b_blue}, {24'b0, m_rgb});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_frame(input logic [3:0] g, input int npix);
        frame_start = 1'b1;
        pix_en      = 1'b1;
        layer_grey  = g;
        tick();
        frame_start = 1'b0;
        repeat (npix) tick();
    endtask

    task automatic start_run();
        restart = 1'b0;
        jump    = 1'b0;
        tick();
        jump = 1'b1;
        tick();
        jump = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Colour vectors: each row is one clock; exp is the colour after it.
    // ------------------------------------------------------------------
    typedef struct {
        bit         pix;
        bit         fs;
        bit         nt;
        logic [3:0] w;
        logic [3:0] g;
        logic [9:0] xx;
        logic [8:0] yy;
        bit         c;
        logic [7:0] e;
    } vec_t;

    function automatic vec_t mk(input bit pix, input bit fs, input bit nt,
                                input logic [3:0] w, input logic [3:0] g,
                                input logic [9:0] xx, input logic [8:0] yy,
                                input bit c, input logic [7:0] e);
        vec_t v;
        v.pix = pix; v.fs = fs; v.nt = nt; v.w = w; v.g = g;
        v.xx = xx; v.yy = yy; v.c = c; v.e = e;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int fcount;
        int sel;

        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0000,   0, 100, 0, 8'h00));
        tbl.push_back(mk(1, 0, 0, 4'b0001, 4'b0010, 100, 100, 1, 8'h00));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0010, 100, 100, 1, 8'hFF));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0000, 100, 100, 1, 8'h00));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0000,   0, 100, 1, 8'hFF));
        tbl.push_back(mk(0, 0, 0, 4'b0001, 4'b0000, 100, 100, 1, 8'hFF));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0000, 640, 480, 1, 8'h00));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0000, 641, 480, 1, 8'hFF));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0000,   1,   1, 1, 8'h00));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0000,   1,   0, 1, 8'hFF));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0000, 100, 481, 1, 8'h00));
        tbl.push_back(mk(0, 1, 1, 4'b0000, 4'b0000, 100, 100, 1, 8'h00));
        tbl.push_back(mk(1, 0, 0, 4'b0001, 4'b0010, 100, 100, 1, 8'h00));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0010, 100, 100, 1, 8'h00));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0000, 100, 100, 1, 8'hFF));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0000,   0, 100, 1, 8'h00));
        tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0000,   0, 100, 1, 8'h00));
        tbl.push_back(mk(0, 1, 0, 4'b0000, 4'b0000,   0, 100, 1, 8'h00));

        // ---------------- reset ----------------
        rst_n = 1'b0; pix_en = 1'b0; x = '0; y = '0; frame_start = 1'b0;
        layer_grey = '0; layer_white = '0; jump = 1'b0; restart = 1'b0; night = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_state", {30'b0, a_state}, 32'd0);
        rst_n = 1'b1;

        // ---------------- colour table ----------------
        foreach (tbl[i]) begin
            pix_en = tbl[i].pix; frame_start = tbl[i].fs; night = tbl[i].nt;
            layer_white = tbl[i].w; layer_grey = tbl[i].g; x = tbl[i].xx; y = tbl[i].yy;
            tick();
            if (tbl[i].c)
                chk($sformatf("colour_vec%0d", i), {24'b0, a_red, a_green, a_blue}, {24'b0, tbl[i].e});
        end
        frame_start = 1'b0; night = 1'b0; layer_white = '0; x = 10'd100; y = 9'd100;

        // ---------------- start and frame count ----------------
        start_run();
        chk("start_state",  {30'b0, a_state}, 32'h2);
        chk("start_frames", {16'b0, a_frames}, 32'd0);
        repeat (3) do_frame(4'b0000, 2);
        chk("three_frames", {16'b0, a_frames}, 32'd3);

        // ---------------- grace period ----------------
        restart = 1'b1; tick(); restart = 1'b0;
        start_run();
        fcount = 0;
        while (a_state != 2'b01 && fcount < 20) begin
            do_frame(4'b0101, 3);
            fcount++;
        end
        chk("grace_death_frame", fcount, 32'd9);
        chk("grace_hit_layer", {28'b0, a_hit}, 32'h4);
        chk("grace_collided", {31'b0, a_coll}, 32'd1);

        // ---------------- collision mask ----------------
        repeat (20 - fcount) do_frame(4'b0101, 3);
        chk("mask_b_survives", {30'b0, b_state}, 32'h2);
        do_frame(4'b1001, 3);
        do_frame(4'b0000, 0);
        chk("mask_b_dead", {30'b0, b_state}, 32'h1);
        chk("mask_b_hit", {28'b0, b_hit}, 32'h8);

        // ---------------- restart priority ----------------
        restart = 1'b1; tick(); restart = 1'b0;
        start_run();
        repeat (8) do_frame(4'b0101, 3);
        chk("prio_pre_run", {30'b0, a_state}, 32'h2);
        restart = 1'b1; frame_start = 1'b1; pix_en = 1'b1;
        tick();
        restart = 1'b0; frame_start = 1'b0;
        chk("prio_state", {30'b0, a_state}, 32'h0);
        chk("prio_hit", {28'b0, a_hit}, 32'h0);

        // ---------------- async reset mid-run ----------------
        layer_grey = '0; x = 10'd100; y = 9'd100;
        start_run();
        repeat (500) do_frame(4'b0000, 0);
        chk("frames_500", {16'b0, a_frames}, 32'd500);
        #2;
        rst_n = 1'b0;
        jump  = 1'b1;
        #1;
        model_reset();
        chk("areset_state",  {30'b0, a_state}, 32'd0);
        chk("areset_frames", {16'b0, a_frames}, 32'd0);
        chk("areset_rgb",    {24'b0, a_red, a_green, a_blue}, 32'd0);
        chk("areset_coll",   {31'b0, a_coll}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pix_en = 1'b1; layer_grey = '0; layer_white = '0;
        repeat (2) tick();
        chk("post_reset_rgb", {24'b0, a_red, a_green, a_blue}, 32'hFF);
        chk("held_jump_idle", {30'b0, a_state}, 32'h0);

        // ---------------- random ----------------
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) jump = ~jump;
            restart     = ($urandom_range(0, 63) == 0);
            frame_start = ($urandom_range(0, 15) == 0);
            pix_en      = ($urandom_range(0, 3) != 0);
            layer_grey  = 4'($urandom);
            layer_white = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            night       = 1'($urandom);
            sel = $urandom_range(0, 5);
            case (sel)
                0: x = 10'd0;
                1: x = 10'd640;
                2: x = 10'd641;
                default: x = 10'($urandom);
            endcase
            sel = $urandom_range(0, 5);
            case (sel)
                0: y = 9'd0;
                1: y = 9'd480;
                2: y = 9'd481;
                default: y = 9'($urandom);
            endcase
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_compositor.md
GAME_COMPOSITOR -- requirements
Module: game_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of sprite layers; layer 0 is the player, 2..8 allowed.
REQ-002 SHALL have parameter COLL_MASK, default all-ones of NUM_LAYERS bits, selecting the layers that kill the player; bit 0 ignored.
REQ-003 SHALL have parameter GRACE_FRAMES, default 8, the number of frames after game start during which collisions are ignored.
REQ-004 SHALL have parameters SCREEN_W (default 640) and SCREEN_H (default 480), the visible area.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 pix_en  in  1  pixel strobe; pipeline advances only when high.
REQ-008 x  in  10  pixel scan X; y  in  9  pixel scan Y.
REQ-009 frame_start  in  1  one-cycle pulse at first pixel of each frame.
REQ-010 layer_grey  in  NUM_LAYERS  per-layer dark-pixel flag; layer_white  in  NUM_LAYERS  per-layer light-pixel flag.
REQ-011 jump, restart, night  in  1 each  synchronous game-control levels.
REQ-012 vgaRed  out 3, vgaGreen  out 3, vgaBlue  out 2  registered colour.
REQ-013 state  out 2  game state; bit1 = run, bit0 = dead.
REQ-014 collided  out 1  high while in DEAD; hit_layer  out NUM_LAYERS  layers that caused death.
REQ-015 frames_alive  out 16  frames survived in the current or last run.

Function
REQ-016 FSM states SHALL be IDLE=2'b00, RUN=2'b10, DEAD=2'b01; 2'b11 SHALL never be output, and any stray value SHALL recover to IDLE on the next clk.
REQ-017 IDLE->RUN SHALL occur on the rising edge of jump (low on the previous clk, high on this one); a jump held through reset SHALL NOT start the game.
REQ-018 RUN->DEAD SHALL occur only on the clk where frame_start=1 and the frame hit accumulator is non-zero.
REQ-019 DEAD->IDLE, and RUN->IDLE, SHALL occur on any clk with restart=1; restart SHALL have priority over jump and over collision on the same clk.
REQ-020 Hit detection, on pix_en in RUN with grace expired: acc |= {layer_grey[N-1:1] & COLL_MASK[N-1:1] & {N-1{layer_grey[0]}}, 1'b0}.
REQ-021 The accumulator SHALL clear on every frame_start and on every state change; pixels on the frame_start clk SHALL count toward the new frame.
REQ-022 hit_layer SHALL load the accumulator on the RUN->DEAD transition, hold through DEAD, and clear on entry to IDLE.
REQ-023 Grace counter SHALL load GRACE_FRAMES on RUN entry and decrement on each frame_start in RUN until 0; collisions count only when it is 0; GRACE_FRAMES=0 means no grace.
REQ-024 frames_alive SHALL increment, saturating at 16'hFFFF, on each frame_start in RUN; it SHALL clear on IDLE->RUN and hold in DEAD and IDLE.
REQ-025 Compositor stage 1 SHALL register on pix_en: anyWhite=|layer_white, anyGrey=|layer_grey, inScreen=(x>0 && x<=SCREEN_W && y>0 && y<=SCREEN_H).
REQ-026 Colour priority in stage 2: anyWhite gives light, else anyGrey gives dark, else inScreen gives light, else black.
REQ-027 Light SHALL be all-ones and dark all-zeros; with night mode active, light and dark SHALL swap; black outside the screen SHALL never invert.
REQ-028 The night input SHALL be sampled only on frame_start so the palette never changes mid-frame.
REQ-029 Colour latency SHALL be exactly 2 pix_en strobes from x/y/layer inputs to vga outputs; outputs SHALL hold when pix_en=0.
REQ-030 collided SHALL equal (state==DEAD), registered with the state.

Reset
REQ-031 rst_n low SHALL asynchronously force: state=IDLE, collided=0, hit_layer=0, frames_alive=0, accumulator=0, grace=0, night mode off, pipeline registers 0, vga outputs 0, jump edge history = 1.
REQ-032 Reset deassertion mid-frame SHALL give correct colour after 2 pix_en strobes; state SHALL stay IDLE until a fresh jump edge.

Verification
REQ-033 Start: reset, jump 0->1 -> state=2'b10 on the next clk, frames_alive=0; 3 frame_start pulses -> frames_alive=3.
REQ-034 Grace: GRACE_FRAMES=8, overlap layer 0 and layer 2 on every frame from RUN entry -> DEAD at the 9th frame_start, hit_layer=4'b0100, collided=1.
REQ-035 Mask: COLL_MASK=4'b1011, overlap with layer 2 only for 20 frames -> stays RUN; overlap with layer 3 -> DEAD at the next frame_start, hit_layer=4'b1000.
REQ-036 Priority: restart and a pending-hit frame_start on the same clk -> state=IDLE, hit_layer=0.
REQ-037 Colour: inputs layer_white=0001, layer_grey=0010, then 0000/0010, then 0000/0000 at x=100,y=100, then x=0 -> after 2 pix_en strobes outputs FF/00/FF/00 (8-bit {R,G,B}); with night set at frame_start -> 00/FF/00/00.
REQ-038 Async reset mid-RUN with frames_alive=500 -> all outputs 0 immediately, no clk edge needed.
